// File: rtl/otter_pipe_pkg.sv
// Shared types and constants for the OTTER pipeline hazard logic.
// One scoreboard entry describes the instruction held in a post-decode stage.
package otter_pipe_pkg;

  localparam int DEF_DEPTH      = 3;
  localparam int DEF_LOAD_AVAIL = 2;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
    logic       load;
  } sb_entry_t;

  // x0 is hardwired to zero, so an entry writing it never produces a value.
  function automatic logic is_producer(input sb_entry_t e);
    return e.valid && e.wr && (e.rd != 5'd0);
  endfunction

endpackage

// File: rtl/otter_src_match.sv
// Priority matcher for one decode source against the forwardable scoreboard entries.
// Reports any hit, the youngest matching entry index, and whether a too-young load matched.
module otter_src_match
  import otter_pipe_pkg::*;
#(
  parameter int N          = DEF_DEPTH - 1,
  parameter int LOAD_AVAIL = DEF_LOAD_AVAIL,
  parameter int IDX_W      = 2
) (
  input  sb_entry_t [N-1:0] entries,
  input  logic [4:0]        addr,
  input  logic              used,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              load_hit
);

  // Walk oldest to youngest so the youngest match is the one left in idx.
  always_comb begin
    hit      = 1'b0;
    idx      = '0;
    load_hit = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (used && is_producer(entries[k]) && (entries[k].rd == addr)) begin
        hit = 1'b1;
        idx = IDX_W'(k);
        if (entries[k].load && ((k + 1) < LOAD_AVAIL)) begin
          load_hit = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/otter_hazard_unit.sv
// Load-use stall, redirect flush and operand-forward select generation for the OTTER pipeline.
// A shift-register scoreboard tracks destination info for each post-decode stage.
module otter_hazard_unit
  import otter_pipe_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LOAD_AVAIL = DEF_LOAD_AVAIL,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ID_VALID,
  input  logic [4:0]       ID_RS1_ADDR,
  input  logic [4:0]       ID_RS2_ADDR,
  input  logic             ID_RS1_USED,
  input  logic             ID_RS2_USED,
  input  logic [4:0]       ID_RD_ADDR,
  input  logic             ID_RD_WR,
  input  logic             ID_IS_LOAD,
  input  logic             EX_REDIRECT,
  input  logic             CNT_CLR,
  output logic             ISSUE,
  output logic             STALL_IF,
  output logic             STALL_ID,
  output logic             FLUSH_IF,
  output logic             FLUSH_ID,
  output logic             BUBBLE_EX,
  output logic [SEL_W-1:0] FWD_SEL_A,
  output logic [SEL_W-1:0] FWD_SEL_B,
  output logic [CNT_W-1:0] STALL_CNT
);

  sb_entry_t [DEPTH-1:0] sb;
  sb_entry_t             id_entry;

  logic             hit_a, hit_b;
  logic             load_a, load_b;
  logic [SEL_W-1:0] idx_a, idx_b;
  logic             hazard, redirect, stall;
  logic [SEL_W-1:0] fwd_a_nxt, fwd_b_nxt;

  // The oldest entry is only kept for pipeline bookkeeping: the register file is write-first.
  logic unused_wb;
  assign unused_wb = ^sb[DEPTH-1];

  otter_src_match #(
    .N          (DEPTH - 1),
    .LOAD_AVAIL (LOAD_AVAIL),
    .IDX_W      (SEL_W)
  ) u_match_a (
    .entries  (sb[DEPTH-2:0]),
    .addr     (ID_RS1_ADDR),
    .used     (ID_RS1_USED),
    .hit      (hit_a),
    .idx      (idx_a),
    .load_hit (load_a)
  );

  otter_src_match #(
    .N          (DEPTH - 1),
    .LOAD_AVAIL (LOAD_AVAIL),
    .IDX_W      (SEL_W)
  ) u_match_b (
    .entries  (sb[DEPTH-2:0]),
    .addr     (ID_RS2_ADDR),
    .used     (ID_RS2_USED),
    .hit      (hit_b),
    .idx      (idx_b),
    .load_hit (load_b)
  );

  // A redirect with nothing in EX is stale and ignored; when honoured it beats any stall.
  assign hazard   = load_a | load_b;
  assign redirect = EX_REDIRECT & sb[STG_EX].valid;
  assign stall    = ID_VALID & hazard & ~redirect;

  assign ISSUE     = ID_VALID & ~hazard & ~redirect;
  assign STALL_IF  = stall;
  assign STALL_ID  = stall;
  assign FLUSH_IF  = redirect;
  assign FLUSH_ID  = redirect;
  assign BUBBLE_EX = stall | redirect;

  assign id_entry  = {1'b1, ID_RD_ADDR, ID_RD_WR, ID_IS_LOAD};
  assign fwd_a_nxt = (ISSUE && hit_a) ? idx_a + SEL_W'(1) : '0;
  assign fwd_b_nxt = (ISSUE && hit_b) ? idx_b + SEL_W'(1) : '0;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      sb        <= '0;
      FWD_SEL_A <= '0;
      FWD_SEL_B <= '0;
      STALL_CNT <= '0;
    end else begin
      sb[STG_EX] <= ISSUE ? id_entry : '0;
      for (int k = 1; k < DEPTH; k++) begin
        sb[k] <= sb[k-1];
      end
      FWD_SEL_A <= fwd_a_nxt;
      FWD_SEL_B <= fwd_b_nxt;
      if (CNT_CLR) begin
        STALL_CNT <= '0;
      end else if (STALL_ID && (STALL_CNT != '1)) begin
        STALL_CNT <= STALL_CNT + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_otter_hazard_unit.sv
// Directed bench for otter_hazard_unit: default instance plus a DEPTH=4/LOAD_AVAIL=3 instance
// with a narrow counter so saturation is reachable; expectations go through a queue.
module tb_otter_hazard_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST;
  logic       id_valid, u1, u2, wr, ld, redir, cnt_clr;
  logic [4:0] rs1, rs2, rd;

  logic       issue, stall_if, stall_id, flush_if, flush_id, bubble;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] cnt;

  logic       issue4, stall_if4, stall_id4, flush_if4, flush_id4, bubble4;
  logic [1:0] fwd_a4, fwd_b4;
  logic [2:0] cnt4;

  otter_hazard_unit dut (
    .CLK(CLK), .RST(RST), .ID_VALID(id_valid),
    .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .ID_RD_ADDR(rd), .ID_RD_WR(wr), .ID_IS_LOAD(ld),
    .EX_REDIRECT(redir), .CNT_CLR(cnt_clr),
    .ISSUE(issue), .STALL_IF(stall_if), .STALL_ID(stall_id),
    .FLUSH_IF(flush_if), .FLUSH_ID(flush_id), .BUBBLE_EX(bubble),
    .FWD_SEL_A(fwd_a), .FWD_SEL_B(fwd_b), .STALL_CNT(cnt)
  );

  otter_hazard_unit #(.DEPTH(4), .LOAD_AVAIL(3), .CNT_W(3)) dut4 (
    .CLK(CLK), .RST(RST), .ID_VALID(id_valid),
    .ID_RS1_ADDR(rs1), .ID_RS2_ADDR(rs2), .ID_RS1_USED(u1), .ID_RS2_USED(u2),
    .ID_RD_ADDR(rd), .ID_RD_WR(wr), .ID_IS_LOAD(ld),
    .EX_REDIRECT(redir), .CNT_CLR(cnt_clr),
    .ISSUE(issue4), .STALL_IF(stall_if4), .STALL_ID(stall_id4),
    .FLUSH_IF(flush_if4), .FLUSH_ID(flush_id4), .BUBBLE_EX(bubble4),
    .FWD_SEL_A(fwd_a4), .FWD_SEL_B(fwd_b4), .STALL_CNT(cnt4)
  );

  localparam int S_ISSUE = 0,  S_STIF = 1,  S_STID = 2,  S_FLIF = 3,  S_FLID = 4;
  localparam int S_BUB   = 5,  S_FA   = 6,  S_FB   = 7,  S_CNT  = 8;
  localparam int S4_ISSUE = 10, S4_STIF = 11, S4_STID = 12, S4_FLIF = 13, S4_FLID = 14;
  localparam int S4_BUB   = 15, S4_FA   = 16, S4_FB   = 17, S4_CNT  = 18;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] obs(input int sig);
    case (sig)
      S_ISSUE:  return 32'(issue);
      S_STIF:   return 32'(stall_if);
      S_STID:   return 32'(stall_id);
      S_FLIF:   return 32'(flush_if);
      S_FLID:   return 32'(flush_id);
      S_BUB:    return 32'(bubble);
      S_FA:     return 32'(fwd_a);
      S_FB:     return 32'(fwd_b);
      S_CNT:    return 32'(cnt);
      S4_ISSUE: return 32'(issue4);
      S4_STIF:  return 32'(stall_if4);
      S4_STID:  return 32'(stall_id4);
      S4_FLIF:  return 32'(flush_if4);
      S4_FLID:  return 32'(flush_id4);
      S4_BUB:   return 32'(bubble4);
      S4_FA:    return 32'(fwd_a4);
      S4_FB:    return 32'(fwd_b4);
      S4_CNT:   return 32'(cnt4);
      default:  return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string tag, input int sig, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic set_id(input logic v, input logic [4:0] a1, input logic e1,
                        input logic [4:0] a2, input logic e2,
                        input logic [4:0] d, input logic w, input logic l);
    id_valid = v;
    rs1 = a1; u1 = e1;
    rs2 = a2; u2 = e2;
    rd = d; wr = w; ld = l;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // Inputs were driven 1ns after the edge; sample 3ns later, then move to the next edge.
  task automatic step();
    exp_t        e;
    logic [31:0] o;
    #3;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.sig);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b0; redir = 1'b0; cnt_clr = 1'b0;
    idle();
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // reset state with a valid instruction waiting in ID
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
    ex("rst_issue", S_ISSUE, 1);   ex("rst_stall_id", S_STID, 0);
    ex("rst_flush_if", S_FLIF, 0); ex("rst_bubble", S_BUB, 0);
    ex("rst_fwd_a", S_FA, 0);      ex("rst_fwd_b", S_FB, 0);
    ex("rst_cnt", S_CNT, 0);       ex("rst_issue4", S4_ISSUE, 1);
    ex("rst_cnt4", S4_CNT, 0);
    step();
    RST = 1'b1;
    idle();
    step();

    // ALU producer followed by a consumer of x5
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    ex("alu_issue", S_ISSUE, 1);
    step();
    set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    ex("alu_use_issue", S_ISSUE, 1); ex("alu_use_nostall", S_STID, 0); ex("alu_use_nobub", S_BUB, 0);
    step();
    idle();
    ex("alu_fwd_a", S_FA, 1); ex("alu_fwd_b", S_FB, 0);
    step();

    // load-use on rs2: one stall cycle, then forward from MEM
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1);
    ex("lw6_issue", S_ISSUE, 1);
    step();
    set_id(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd11, 1'b1, 1'b0);
    ex("lu_stall_id", S_STID, 1); ex("lu_stall_if", S_STIF, 1); ex("lu_bubble", S_BUB, 1);
    ex("lu_issue", S_ISSUE, 0);   ex("lu_flush_if", S_FLIF, 0);
    step();
    ex("lu_release_issue", S_ISSUE, 1); ex("lu_release_stall", S_STID, 0);
    ex("lu_release_bub", S_BUB, 0);     ex("lu_cnt", S_CNT, 1);
    step();
    idle();
    ex("lu_fwd_b", S_FB, 2); ex("lu_fwd_a", S_FA, 0); ex("lu_cnt_hold", S_CNT, 1);
    step();

    // CNT_CLR during a stall cycle wins over the increment
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    cnt_clr = 1'b1;
    ex("clr_stall", S_STID, 1);
    step();
    cnt_clr = 1'b0;
    ex("clr_release", S_ISSUE, 1); ex("clr_prio_cnt", S_CNT, 0);
    step();

    // redirect in the same cycle as a load-use hazard
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    ex("lw9_issue", S_ISSUE, 1);
    step();
    set_id(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    redir = 1'b1;
    ex("rd_flush_if", S_FLIF, 1); ex("rd_flush_id", S_FLID, 1); ex("rd_bubble", S_BUB, 1);
    ex("rd_stall_id", S_STID, 0); ex("rd_stall_if", S_STIF, 0); ex("rd_issue", S_ISSUE, 0);
    step();
    redir = 1'b0;
    idle();
    ex("rd_cnt_same", S_CNT, 0); ex("rd_fwd_a", S_FA, 0);
    step();
    step();
    step();

    // x0 never matches, even as a load destination
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    ex("x0_nostall", S_STID, 0); ex("x0_issue", S_ISSUE, 1);
    step();
    idle();
    ex("x0_fwd_a", S_FA, 0); ex("x0_fwd_b", S_FB, 0);
    step();

    // two producers of x8: youngest wins
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    step();
    step();
    set_id(1'b1, 5'd8, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    ex("x8_issue", S_ISSUE, 1); ex("x8_nostall", S_STID, 0);
    step();
    idle();
    ex("x8_fwd_a", S_FA, 1); ex("x8_fwd_b", S_FB, 1);
    step();
    // x8 producer now only in WB: write-first register file supplies it
    set_id(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("wb_issue", S_ISSUE, 1);
    step();
    idle();
    ex("wb_fwd_a", S_FA, 0);
    step();

    // deeper pipe: load available from stage 2
    RST = 1'b0;
    step();
    RST = 1'b1;
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    ex("d4_lw_issue", S4_ISSUE, 1);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("d4_stall1", S4_STID, 1); ex("d4_bub1", S4_BUB, 1); ex("d4_issue1", S4_ISSUE, 0);
    step();
    ex("d4_stall2", S4_STID, 1); ex("d4_stall_if2", S4_STIF, 1);
    step();
    ex("d4_release", S4_ISSUE, 1); ex("d4_release_stall", S4_STID, 0); ex("d4_cnt", S4_CNT, 2);
    step();
    idle();
    ex("d4_fwd_a", S4_FA, 3); ex("d4_fwd_b", S4_FB, 0); ex("d4_cnt_hold", S4_CNT, 2);
    step();

    // three more load-use rounds push the 3-bit counter past all-ones
    for (int r = 0; r < 3; r++) begin
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      step();
      step();
    end
    idle();
    ex("d4_sat", S4_CNT, 7);
    step();

    // stall again at saturation, then reset in the middle of the stall
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    step();
    set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex("d4_sat_stall", S4_STID, 1); ex("d4_sat_cnt", S4_CNT, 7);
    step();
    ex("d4_sat_stall2", S4_STID, 1); ex("d4_sat_hold", S4_CNT, 7);
    RST = 1'b0;
    step();
    RST = 1'b1;
    ex("mr_issue4", S4_ISSUE, 1); ex("mr_stall_id4", S4_STID, 0); ex("mr_stall_if4", S4_STIF, 0);
    ex("mr_bub4", S4_BUB, 0);     ex("mr_flush_if4", S4_FLIF, 0); ex("mr_flush_id4", S4_FLID, 0);
    ex("mr_fwd_a4", S4_FA, 0);    ex("mr_cnt4", S4_CNT, 0);
    ex("mr_cnt", S_CNT, 0);       ex("mr_issue", S_ISSUE, 1);
    step();
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otter_hazard_unit.md
OTTER_HAZARD_UNIT -- requirements
Module: otter_hazard_unit

Interface
REQ-001 Parameter DEPTH, default 3: tracked post-decode stages; index 0=EX, 1=MEM, 2=WB; legal range 3..8.
REQ-002 Parameter LOAD_AVAIL, default 2: first stage index from which load data is forwardable; legal range 1..DEPTH-1.
REQ-003 Parameter CNT_W, default 16: stall counter width.
REQ-004 One clock; reset is synchronous and active-low. Ports are CLK and RST.
REQ-005 CLK  in  1  clock; all state changes on rising edge.
REQ-006 RST  in  1  synchronous active-low reset.
REQ-007 ID_VALID  in  1  decode stage holds a valid instruction.
REQ-008 ID_RS1_ADDR, ID_RS2_ADDR  in  5 each  source register addresses.
REQ-009 ID_RS1_USED, ID_RS2_USED  in  1 each  source actually read.
REQ-010 ID_RD_ADDR  in  5; ID_RD_WR  in  1; ID_IS_LOAD  in  1  destination, write enable, load flag.
REQ-011 EX_REDIRECT  in  1  taken branch or jump resolved in EX this cycle.
REQ-012 CNT_CLR  in  1  clears stall counter.
REQ-013 ISSUE  out  1  ID instruction advances to EX at this edge.
REQ-014 STALL_IF, STALL_ID  out  1  hold PC and IF register / hold ID register.
REQ-015 FLUSH_IF, FLUSH_ID  out  1  squash IF / ID contents.
REQ-016 BUBBLE_EX  out  1  EX register loads a NOP at this edge.
REQ-017 FWD_SEL_A, FWD_SEL_B  out  $clog2(DEPTH)  registered operand select for the instruction in EX; 0=ID-read data, k=result of stage k.
REQ-018 STALL_CNT  out  CNT_W  saturating count of load-use stall cycles.

Function
REQ-019 Scoreboard: DEPTH entries {valid, rd, wr, load}; each edge entry[k] <= entry[k-1] for k>=1; entry[0] <= ID fields if ISSUE, else invalid entry.
REQ-020 An entry is a producer only if valid, wr=1, rd!=0.
REQ-021 Source match: USED=1 and address equals producer rd; x0 never matches.
REQ-022 Load-use hazard: any source matches a load producer at entry j with j+1 < LOAD_AVAIL.
REQ-023 STALL_IF = STALL_ID = BUBBLE_EX = ID_VALID & hazard & !EX_REDIRECT; combinational, same cycle.
REQ-024 ISSUE = ID_VALID & !hazard & !EX_REDIRECT.
REQ-025 EX_REDIRECT is honoured only when entry[0] valid; then FLUSH_IF = FLUSH_ID = BUBBLE_EX = 1 and stall outputs are 0 (redirect beats stall).
REQ-026 On ISSUE, FWD_SEL_x <= j+1 for the youngest (lowest j) matching producer with j <= DEPTH-2, else 0; otherwise FWD_SEL_x <= 0.
REQ-027 Matches against entry[DEPTH-1] are ignored; register file is write-first.
REQ-028 Hazard persists for exactly LOAD_AVAIL-1-j cycles; no extra stall after the load reaches stage LOAD_AVAIL-1.
REQ-029 STALL_CNT increments by 1 per cycle STALL_ID=1, saturates at all-ones; CNT_CLR has priority over increment.

Reset
REQ-030 RST=0 at an edge: all entries invalid, FWD_SEL_A/B=0, STALL_CNT=0; combinational outputs then evaluate to ISSUE=ID_VALID, all stall/flush/bubble 0.
REQ-031 Reset mid-stall or mid-redirect discards pending state; no stall or flush carries over.

Structure
REQ-032 Package otter_pipe_pkg holds sb_entry_t struct, stage-index constants, default DEPTH/LOAD_AVAIL.
REQ-033 One sub-module otter_src_match: combinational priority matcher (one source vs all entries, returns hit, youngest index, load-hit); instantiated twice.

Verification
REQ-034 ALU add x5 issued, next cycle ID reads x5 -> no stall, ISSUE=1, FWD_SEL_A=1 in following cycle.
REQ-035 lw x6 then add reading x6 as rs2 -> exactly 1 cycle STALL_ID/BUBBLE_EX, then FWD_SEL_B=2, STALL_CNT=1.
REQ-036 LOAD_AVAIL=3, DEPTH=4, lw x7 then consumer -> 2 stall cycles, then FWD_SEL=3.
REQ-037 Load-use hazard with EX_REDIRECT=1 same cycle -> FLUSH_IF=FLUSH_ID=1, STALL_ID=0, ISSUE=0, STALL_CNT unchanged.
REQ-038 Producer writes x0, consumer reads x0 -> no stall, FWD_SEL=0; two producers of x8 at entries 0 and 1 -> FWD_SEL=1.
REQ-039 STALL_CNT preloaded to 16'hFFFF by repeated stalls -> holds; RST=0 mid-stall -> next cycle all outputs at reset values.
